// File: rtl/fixed_broadcast_tree_if.sv
// Bus bundle for fixed_broadcast_tree: one valid/ready input beat and OUT_SIZE
// independent valid/ready output lanes.
//   data_in / data_in_valid / data_in_ready        producer side
//   data_out / data_out_valid / data_out_ready     per-lane consumer side
// Modports:
//   slave  - the broadcast block itself
//   master - the surrounding producer and consumers
interface fixed_broadcast_tree_if #(
    parameter int unsigned OUT_SIZE  = 4,
    parameter int unsigned IN_WIDTH  = 32,
    parameter int unsigned OUT_WIDTH = IN_WIDTH
);
    logic [IN_WIDTH-1:0]                 data_in;
    logic                                data_in_valid;
    logic                                data_in_ready;
    logic [OUT_SIZE-1:0][OUT_WIDTH-1:0]  data_out;
    logic [OUT_SIZE-1:0]                 data_out_valid;
    logic [OUT_SIZE-1:0]                 data_out_ready;

    modport slave (
        input  data_in,
        input  data_in_valid,
        output data_in_ready,
        output data_out,
        output data_out_valid,
        input  data_out_ready
    );

    modport master (
        output data_in,
        output data_in_valid,
        input  data_in_ready,
        input  data_out,
        input  data_out_valid,
        output data_out_ready
    );
endinterface

// File: rtl/fixed_broadcast_tree.sv
// fixed_broadcast_tree: accepts one fixed-point beat on a valid/ready input
// and delivers it, zero-extended to OUT_WIDTH, to OUT_SIZE independent
// valid/ready lanes. Each lane takes the beat at its own pace; a new beat is
// accepted only once every lane has taken the held one.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-low reset
//   bus (slave)    data_in/data_in_valid/data_in_ready input handshake,
//                  data_out/data_out_valid/data_out_ready per-lane outputs
//
// Build option:
//   FIXED_BROADCAST_PASSTHRU_EN - when defined, data_in_ready also asserts in
//   the cycle the last owed lanes fire, giving 1 beat/cycle at the cost of a
//   combinational data_out_ready -> data_in_ready path. When undefined, ready
//   depends on registered state only (at most 1 beat per 2 cycles).
module fixed_broadcast_tree #(
    parameter int unsigned OUT_SIZE  = 4,
    parameter int unsigned IN_WIDTH  = 32,
    parameter int unsigned OUT_WIDTH = IN_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    fixed_broadcast_tree_if.slave  bus
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e                 state_q;
    state_e                 state_d;
    logic [OUT_WIDTH-1:0]   data_q;
    logic [OUT_WIDTH-1:0]   data_d;
    logic [OUT_SIZE-1:0]    pending_q;
    logic [OUT_SIZE-1:0]    pending_d;
    logic [OUT_SIZE-1:0]    lane_fire;
    logic                   in_ready;
    logic                   in_fire;

    // A lane only handshakes while it is still owed the held beat.
    assign lane_fire = pending_q & bus.data_out_ready;

    // Ready is held low during reset so a producer never sees a beat
    // "accepted" that the cleared registers then drop.
`ifdef FIXED_BROADCAST_PASSTHRU_EN
    assign in_ready = rst & ~|(pending_q & ~bus.data_out_ready);
`else
    assign in_ready = rst & (state_q == IDLE);
`endif

    assign in_fire           = bus.data_in_valid & in_ready;
    assign bus.data_in_ready = in_ready;

    // Next-state: retire fired lanes, then let an input handshake reload.
    // A reload in the same cycle as the final lane fire wins, so no lane is
    // offered the old beat again.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        data_d    = data_q;
        case (state_q)
            IDLE: begin
                if (in_fire) begin
                    data_d    = OUT_WIDTH'(bus.data_in);
                    pending_d = '1;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                pending_d = pending_q & ~lane_fire;
                if (in_fire) begin
                    data_d    = OUT_WIDTH'(bus.data_in);
                    pending_d = '1;
                end
                state_d = (pending_d == '0) ? IDLE : BUSY;
            end
            default: begin
                state_d   = IDLE;
                pending_d = '0;
            end
        endcase
    end

    // State registers; reset drops any held beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            data_q    <= data_d;
        end
    end

    // Outputs come straight from registers: every lane sees the held beat.
    assign bus.data_out       = {OUT_SIZE{data_q}};
    assign bus.data_out_valid = pending_q;

endmodule

// File: tb/tb_fixed_broadcast_tree.sv
// Directed bench for fixed_broadcast_tree (OUT_SIZE=4, IN_WIDTH=8,
// OUT_WIDTH=12). Accepted beats are pushed to a scoreboard history; each lane
// keeps a read index into it and checks every beat it receives.
module tb_fixed_broadcast_tree;

    localparam int unsigned OUT_SIZE  = 4;
    localparam int unsigned IN_WIDTH  = 8;
    localparam int unsigned OUT_WIDTH = 12;
`ifdef FIXED_BROADCAST_PASSTHRU_EN
    localparam int STREAM_CYCLES = 8;
`else
    localparam int STREAM_CYCLES = 16;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;

    fixed_broadcast_tree_if #(
        .OUT_SIZE (OUT_SIZE),
        .IN_WIDTH (IN_WIDTH),
        .OUT_WIDTH(OUT_WIDTH)
    ) bus ();

    fixed_broadcast_tree #(
        .OUT_SIZE (OUT_SIZE),
        .IN_WIDTH (IN_WIDTH),
        .OUT_WIDTH(OUT_WIDTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    logic [OUT_WIDTH-1:0] beats [$];
    int                   rd_idx   [OUT_SIZE];
    int                   lane_cnt [OUT_SIZE];
    int                   n_assert = 0;
    int                   n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Settle, score the handshakes of this cycle, advance to the next negedge.
    task automatic cycle(output bit in_fired);
        #1;
        in_fired = 1'b0;
        for (int j = 0; j < OUT_SIZE; j++) begin
            if (bus.data_out_valid[j] && bus.data_out_ready[j]) begin
                check($sformatf("lane%0d_owed_beat", j), 32'(rd_idx[j] < beats.size()), 32'd1);
                if (rd_idx[j] < beats.size()) begin
                    check($sformatf("lane%0d_data", j), 32'(bus.data_out[j]), 32'(beats[rd_idx[j]]));
                    rd_idx[j]++;
                end
                lane_cnt[j]++;
            end
        end
        if (bus.data_in_valid && bus.data_in_ready) begin
            beats.push_back(OUT_WIDTH'(bus.data_in));
            in_fired = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        bit                   f;
        int                   cyc;
        int                   acc;
        int                   base_cnt [OUT_SIZE];
        logic [OUT_SIZE-1:0]  mask;
        int                   ord [4] = '{2, 0, 3, 1};

        for (int j = 0; j < OUT_SIZE; j++) begin
            rd_idx[j]   = 0;
            lane_cnt[j] = 0;
        end
        bus.data_in        = '0;
        bus.data_in_valid  = 1'b0;
        bus.data_out_ready = '0;

        // Reset held with random inputs.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.data_in        = IN_WIDTH'($urandom);
            bus.data_in_valid  = 1'($urandom);
            bus.data_out_ready = OUT_SIZE'($urandom);
            #1;
            check("rst_valid", 32'(bus.data_out_valid), 32'h0);
            for (int j = 0; j < OUT_SIZE; j++)
                check($sformatf("rst_data%0d", j), 32'(bus.data_out[j]), 32'h0);
        end
        @(negedge clk);
        rst                = 1'b1;
        bus.data_in_valid  = 1'b0;
        bus.data_out_ready = '0;
        #1;
        check("rst_release_ready", 32'(bus.data_in_ready), 32'h1);
        @(negedge clk);

        // Single beat, all lanes ready.
        bus.data_in        = 8'hA5;
        bus.data_in_valid  = 1'b1;
        bus.data_out_ready = '1;
        cycle(f);
        check("single_accept", 32'(f), 32'h1);
        bus.data_in_valid = 1'b0;
        #1;
        check("single_valid", 32'(bus.data_out_valid), 32'hF);
        for (int j = 0; j < OUT_SIZE; j++)
            check($sformatf("single_data%0d", j), 32'(bus.data_out[j]), 32'h0A5);
        cycle(f);
        #1;
        check("single_valid_drop", 32'(bus.data_out_valid), 32'h0);

        // Staggered lanes: 2, 0, 3, 1.
        bus.data_in        = 8'h3C;
        bus.data_in_valid  = 1'b1;
        bus.data_out_ready = '0;
        cycle(f);
        check("stag_accept", 32'(f), 32'h1);
        bus.data_in_valid = 1'b0;
        mask = '1;
        for (int k = 0; k < 4; k++) begin
            bus.data_out_ready = '0;
            #1;
            check($sformatf("stag_valid_%0d", k), 32'(bus.data_out_valid), 32'(mask));
            check($sformatf("stag_ready_%0d", k), 32'(bus.data_in_ready), 32'h0);
            bus.data_out_ready = OUT_SIZE'(1 << ord[k]);
            cycle(f);
            mask = mask & ~OUT_SIZE'(1 << ord[k]);
        end
        bus.data_out_ready = '0;
        #1;
        check("stag_valid_end", 32'(bus.data_out_valid), 32'h0);
        check("stag_ready_end", 32'(bus.data_in_ready), 32'h1);

        // Back-to-back stream of 1..8 with all lanes ready.
        for (int j = 0; j < OUT_SIZE; j++) base_cnt[j] = lane_cnt[j];
        bus.data_out_ready = '1;
        cyc = 0;
        acc = 0;
        while (cyc < 64) begin
            bus.data_in       = IN_WIDTH'(acc + 1);
            bus.data_in_valid = (acc < 8);
            #1;
            if (acc == 8 && bus.data_in_ready) break;
            cycle(f);
            if (f) acc++;
            cyc++;
        end
        check("stream_cycles", 32'(cyc), 32'(STREAM_CYCLES));
        bus.data_in_valid = 1'b0;
        for (int k = 0; k < 3; k++) cycle(f);
        for (int j = 0; j < OUT_SIZE; j++)
            check($sformatf("stream_count%0d", j), 32'(lane_cnt[j] - base_cnt[j]), 32'd8);

        // Backpressure on lane 3.
        bus.data_in        = 8'h5A;
        bus.data_in_valid  = 1'b1;
        bus.data_out_ready = 4'b0111;
        cycle(f);
        check("bp_accept", 32'(f), 32'h1);
        bus.data_in = 8'h66;
        cycle(f);
        check("bp_first_hold", 32'(f), 32'h0);
        for (int k = 0; k < 10; k++) begin
            #1;
            check("bp_data3", 32'(bus.data_out[3]), 32'h05A);
            check("bp_ready", 32'(bus.data_in_ready), 32'h0);
            check("bp_valid", 32'(bus.data_out_valid), 32'h8);
            cycle(f);
            check("bp_hold", 32'(f), 32'h0);
        end
        bus.data_out_ready = '1;
        acc = 0;
        for (int k = 0; k < 4 && acc == 0; k++) begin
            cycle(f);
            if (f) acc = 1;
        end
        check("bp_next_accepted", 32'(acc), 32'h1);
        bus.data_in_valid = 1'b0;
        cycle(f);
        cycle(f);
        #1;
        check("bp_drained", 32'(bus.data_out_valid), 32'h0);

        // Mid-flight reset after lanes 0 and 1 fired.
        bus.data_in        = 8'h77;
        bus.data_in_valid  = 1'b1;
        bus.data_out_ready = '0;
        cycle(f);
        bus.data_in_valid  = 1'b0;
        bus.data_out_ready = 4'b0011;
        cycle(f);
        bus.data_out_ready = '0;
        #1;
        check("mid_valid_pre", 32'(bus.data_out_valid), 32'hC);
        rst = 1'b0;
        #1;
        check("mid_valid_rst", 32'(bus.data_out_valid), 32'h0);
        check("mid_data_rst", 32'(bus.data_out[2]), 32'h0);
        for (int j = 0; j < OUT_SIZE; j++) rd_idx[j] = beats.size();
        @(posedge clk);
        @(negedge clk);
        rst                = 1'b1;
        bus.data_out_ready = '1;
        #1;
        check("mid_ready_release", 32'(bus.data_in_ready), 32'h1);
        for (int k = 0; k < 3; k++) begin
            #1;
            check("mid_no_stale", 32'(bus.data_out_valid), 32'h0);
            cycle(f);
        end
        bus.data_in       = 8'h12;
        bus.data_in_valid = 1'b1;
        cycle(f);
        check("mid_next_accept", 32'(f), 32'h1);
        bus.data_in_valid = 1'b0;
        #1;
        check("mid_next_valid", 32'(bus.data_out_valid), 32'hF);
        check("mid_next_data", 32'(bus.data_out[3]), 32'h012);
        cycle(f);
        for (int j = 0; j < OUT_SIZE; j++)
            check($sformatf("final_consumed%0d", j), 32'(rd_idx[j]), 32'(beats.size()));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
